// File: rtl/regfile_pkg.sv
// Shared widths, types and constants for the multi-port integer register file.
package regfile_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int DEPTH_DEFAULT = 32;
    localparam int AW_DEFAULT    = $clog2(DEPTH_DEFAULT);

    // x0 is hardwired to zero and never tracked as pending.
    localparam int ZERO_REG = 0;

    typedef logic [AW_DEFAULT-1:0]   reg_addr_t;
    typedef logic [XLEN_DEFAULT-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: busy bit per register, set on issue, cleared on writeback; 1-cycle state update.
// No backpressure: rsv_ok_o is combinational and a rejected reservation must be retried by issue.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int DEPTH  = DEPTH_DEFAULT,
    parameter  int NWRITE = 1,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NWRITE-1:0]    wr_en_i,
    input  logic [NWRITE*AW-1:0] wr_addr_i,
    input  logic                 rsv_en_i,
    input  logic [AW-1:0]        rsv_addr_i,
    output logic                 rsv_ok_o,
    output logic [DEPTH-1:0]     busy_o
);

    logic [DEPTH-1:0]            busy_q;
    logic [DEPTH-1:0]            busy_d;
    logic [DEPTH-1:0]            clr;
    logic [NWRITE-1:0][AW-1:0]   wr_addr_v;
    logic                        rsv_zero;

    assign wr_addr_v = wr_addr_i;
    assign rsv_zero  = (rsv_addr_i == AW'(ZERO_REG));

    always_comb begin
        clr = '0;
        for (int j = 0; j < NWRITE; j++) begin
            if (wr_en_i[j]) begin
                clr[wr_addr_v[j]] = 1'b1;
            end
        end
    end

    // A writeback landing this cycle frees the register for a new owner.
    assign rsv_ok_o = resetn & rsv_en_i &
                      (rsv_zero | !busy_q[rsv_addr_i] | clr[rsv_addr_i]);

    always_comb begin
        busy_d = busy_q & ~clr;
        if (rsv_ok_o && !rsv_zero) begin
            busy_d[rsv_addr_i] = 1'b1;
        end
        busy_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-to-read bypass and hazard scoreboard; reads registered, 1-cycle latency.
// No backpressure: read outputs hold while rd_en is low; reservations may be refused via rsv_ok.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN   = XLEN_DEFAULT,
    parameter  int DEPTH  = DEPTH_DEFAULT,
    parameter  int NREAD  = 2,
    parameter  int NWRITE = 1,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NREAD-1:0]       rd_en,
    input  logic [NREAD*AW-1:0]    rd_addr,
    output logic [NREAD*XLEN-1:0]  rd_data,
    output logic [NREAD-1:0]       rd_busy,
    input  logic [NWRITE-1:0]      wr_en,
    input  logic [NWRITE*AW-1:0]   wr_addr,
    input  logic [NWRITE*XLEN-1:0] wr_data,
    input  logic                   rsv_en,
    input  logic [AW-1:0]          rsv_addr,
    output logic                   rsv_ok
);

    typedef logic [AW-1:0]   addr_t;
    typedef logic [XLEN-1:0] data_t;

    addr_t [NREAD-1:0]  rd_addr_v;
    addr_t [NWRITE-1:0] wr_addr_v;
    data_t [NWRITE-1:0] wr_data_v;

    data_t              regs_q [DEPTH];
    data_t              regs_d [DEPTH];
    data_t [NREAD-1:0]  rd_data_q;
    data_t [NREAD-1:0]  rd_data_d;
    logic  [NREAD-1:0]  rd_busy_q;
    logic  [NREAD-1:0]  rd_busy_d;
    logic  [DEPTH-1:0]  busy;

    assign rd_addr_v = rd_addr;
    assign wr_addr_v = wr_addr;
    assign wr_data_v = wr_data;

    regfile_scoreboard #(
        .DEPTH  (DEPTH),
        .NWRITE (NWRITE)
    ) u_scoreboard (
        .clk        (clk),
        .resetn     (resetn),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .rsv_en_i   (rsv_en),
        .rsv_addr_i (rsv_addr),
        .rsv_ok_o   (rsv_ok),
        .busy_o     (busy)
    );

    // Ascending port order makes the highest-index writer win on collisions.
    always_comb begin
        regs_d = regs_q;
        for (int j = 0; j < NWRITE; j++) begin
            if (wr_en[j] && wr_addr_v[j] != addr_t'(ZERO_REG)) begin
                regs_d[wr_addr_v[j]] = wr_data_v[j];
            end
        end
    end

    // Busy comes from the pre-edge scoreboard, so a same-cycle reservation is invisible here.
    always_comb begin
        rd_data_d = rd_data_q;
        rd_busy_d = rd_busy_q;
        for (int i = 0; i < NREAD; i++) begin
            if (rd_en[i]) begin
                rd_data_d[i] = regs_q[rd_addr_v[i]];
                rd_busy_d[i] = busy[rd_addr_v[i]];
                for (int j = 0; j < NWRITE; j++) begin
                    if (wr_en[j] && wr_addr_v[j] == rd_addr_v[i]) begin
                        rd_data_d[i] = wr_data_v[j];
                        rd_busy_d[i] = 1'b0;
                    end
                end
                if (rd_addr_v[i] == addr_t'(ZERO_REG)) begin
                    rd_data_d[i] = '0;
                    rd_busy_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            regs_q    <= '{default: '0};
            rd_data_q <= '0;
            rd_busy_q <= '0;
        end else begin
            regs_q    <= regs_d;
            rd_data_q <= rd_data_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    assign rd_data = rd_data_q;
    assign rd_busy = rd_busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: reads are scoreboarded through per-port queues, rsv_ok checked at issue.
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int DEPTH = 32;
    localparam int NREAD = 2;
    localparam int NWRITE = 2;
    localparam int AW = 5;

    logic                   clk = 1'b0;
    logic                   resetn;
    logic [NREAD-1:0]       rd_en;
    logic [NREAD*AW-1:0]    rd_addr;
    logic [NREAD*XLEN-1:0]  rd_data;
    logic [NREAD-1:0]       rd_busy;
    logic [NWRITE-1:0]      wr_en;
    logic [NWRITE*AW-1:0]   wr_addr;
    logic [NWRITE*XLEN-1:0] wr_data;
    logic                   rsv_en;
    logic [AW-1:0]          rsv_addr;
    logic                   rsv_ok;

    typedef struct {
        logic [XLEN-1:0] d;
        logic            b;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    regfile_mp #(
        .XLEN   (XLEN),
        .DEPTH  (DEPTH),
        .NREAD  (NREAD),
        .NWRITE (NWRITE)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .rsv_ok   (rsv_ok)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int p, input logic [XLEN-1:0] gd,
                         input logic gb, input logic [XLEN-1:0] ed, input logic eb);
        n_cmp++;
        if (gd !== ed || gb !== eb) begin
            n_fail++;
            $display("FAIL %s port%0d: got data=%h busy=%b, want data=%h busy=%b",
                     nm, p, gd, gb, ed, eb);
        end
    endtask

    // Monitor: pops one expectation per issued read; otherwise outputs must hold.
    exp_t            last [NREAD];
    logic [NREAD-1:0] en_s;
    logic             rst_s;
    exp_t             e;

    always @(posedge clk) begin
        en_s  = rd_en;
        rst_s = resetn;
        #1;
        for (int i = 0; i < NREAD; i++) begin
            if (!rst_s) begin
                last[i].d = '0;
                last[i].b = 1'b0;
                check("reset", i, rd_data[i*XLEN +: XLEN], rd_busy[i], '0, 1'b0);
            end else if (en_s[i]) begin
                if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_read port%0d: got a read with no expectation queued", i);
                end else begin
                    e = (i == 0) ? q0.pop_front() : q1.pop_front();
                    check("read", i, rd_data[i*XLEN +: XLEN], rd_busy[i], e.d, e.b);
                    last[i] = e;
                end
            end else begin
                check("hold", i, rd_data[i*XLEN +: XLEN], rd_busy[i], last[i].d, last[i].b);
            end
        end
    end

    task automatic idle();
        rd_en    = '0;
        rd_addr  = '0;
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        rsv_en   = 1'b0;
        rsv_addr = '0;
    endtask

    task automatic rd(input int p, input int a, input logic [XLEN-1:0] d, input logic b);
        exp_t x;
        x.d = d;
        x.b = b;
        rd_en[p] = 1'b1;
        rd_addr[p*AW +: AW] = a[AW-1:0];
        if (p == 0) q0.push_back(x);
        else        q1.push_back(x);
    endtask

    task automatic wr(input int p, input int a, input logic [XLEN-1:0] d);
        wr_en[p] = 1'b1;
        wr_addr[p*AW +: AW] = a[AW-1:0];
        wr_data[p*XLEN +: XLEN] = d;
    endtask

    task automatic rsv(input int a);
        rsv_en   = 1'b1;
        rsv_addr = a[AW-1:0];
    endtask

    // Inputs are applied 2 time units after an edge; rsv_ok is sampled before the next edge.
    task automatic tick(input logic chk, input logic exp_ok, input string nm);
        #1;
        if (chk) begin
            n_cmp++;
            if (rsv_ok !== exp_ok) begin
                n_fail++;
                $display("FAIL %s: rsv_ok got %b, want %b", nm, rsv_ok, exp_ok);
            end
        end
        @(posedge clk);
        #2;
        idle();
    endtask

    initial begin
        resetn = 1'b0;
        idle();
        @(posedge clk);
        #2;
        tick(1'b0, 1'b0, "");
        resetn = 1'b1;

        // Reset state and hold
        rd(0, 5, 32'h0, 1'b0); rd(1, 5, 32'h0, 1'b0);
        tick(1'b0, 1'b0, "");
        tick(1'b0, 1'b0, "");
        tick(1'b0, 1'b0, "");

        // Plain write then read; x0 stays zero
        wr(0, 7, 32'hDEADBEEF);                tick(1'b0, 1'b0, "");
        rd(0, 7, 32'hDEADBEEF, 1'b0);          tick(1'b0, 1'b0, "");
        wr(0, 0, 32'h1234);                    tick(1'b0, 1'b0, "");
        rd(1, 0, 32'h0, 1'b0);                 tick(1'b0, 1'b0, "");

        // Bypass, then storage confirms the write
        wr(0, 3, 32'hA5A5A5A5); rd(0, 3, 32'hA5A5A5A5, 1'b0); tick(1'b0, 1'b0, "");
        rd(1, 3, 32'hA5A5A5A5, 1'b0);          tick(1'b0, 1'b0, "");

        // Two writers to the same register: port 1 wins in storage and bypass
        wr(0, 3, 32'h1); wr(1, 3, 32'h2);      tick(1'b0, 1'b0, "");
        rd(0, 3, 32'h2, 1'b0);                 tick(1'b0, 1'b0, "");
        wr(0, 6, 32'h11); wr(1, 6, 32'h22); rd(1, 6, 32'h22, 1'b0); tick(1'b0, 1'b0, "");

        // Scoreboard: reserve, WAW reject, writeback clear
        rsv(9);                                tick(1'b1, 1'b1, "rsv_x9");
        rd(0, 9, 32'h0, 1'b1); rsv(9);         tick(1'b1, 1'b0, "rsv_x9_waw");
        rd(1, 9, 32'h0, 1'b1);                 tick(1'b0, 1'b0, "");
        wr(0, 9, 32'h55);                      tick(1'b0, 1'b0, "");
        rd(0, 9, 32'h55, 1'b0);                tick(1'b0, 1'b0, "");

        // Same-cycle writeback and reserve: net busy, bypassed read sees the write
        wr(0, 9, 32'h66); rsv(9); rd(0, 9, 32'h66, 1'b0); tick(1'b1, 1'b1, "rsv_x9_with_wr");
        rd(1, 9, 32'h66, 1'b1);                tick(1'b0, 1'b0, "");

        // Reservation not visible to the read in the same cycle
        rsv(10); rd(0, 10, 32'h0, 1'b0);       tick(1'b1, 1'b1, "rsv_x10");
        rd(0, 10, 32'h0, 1'b1);                tick(1'b0, 1'b0, "");

        // x0 reservation always accepted, never busy
        rsv(0);                                tick(1'b1, 1'b1, "rsv_x0");
        rsv(0); rd(1, 0, 32'h0, 1'b0);         tick(1'b1, 1'b1, "rsv_x0_again");

        // Reset mid-operation discards the write and clears the scoreboard
        rsv(4);                                tick(1'b1, 1'b1, "rsv_x4");
        resetn = 1'b0; wr(0, 4, 32'hFF); rsv(4); tick(1'b1, 1'b0, "rsv_in_reset");
        resetn = 1'b1;
        rd(0, 4, 32'h0, 1'b0); rd(1, 7, 32'h0, 1'b0); rsv(4); tick(1'b1, 1'b1, "rsv_x4_after_reset");
        rd(0, 4, 32'h0, 1'b1);                 tick(1'b0, 1'b0, "");
        tick(1'b0, 1'b0, "");

        for (int k = 0; k < 20 && (q0.size() != 0 || q1.size() != 0); k++) begin
            @(posedge clk);
        end
        n_cmp++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d/%0d reads still expected, want 0/0", q0.size(), q1.size());
        end
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file for the core. It succeeds the single-write, edge-strobed register file with the following features:
- clocked storage on clk;
- configurable width, depth and port counts;
- write-to-read bypass;
- a pending-write scoreboard, so the issue stage can detect RAW and WAW hazards.

It sits between decode/issue (read and reserve) and writeback (write and clear).

Parameters:
XLEN, 32, data width of each register
DEPTH, 32, number of registers; power of two, minimum 2
NREAD, 2, number of read ports
NWRITE, 1, number of write ports
AW, $clog2(DEPTH), address width (derived, not overridden)

Ports:
clk  in  1  clock, all state updates on rising edge
resetn  in  1  reset, synchronous, active-low
rd_en  in  NREAD  per-port read request
rd_addr  in  NREAD*AW  per-port read address, port i at [i*AW +: AW]
rd_data  out  NREAD*XLEN  registered read data
rd_busy  out  NREAD  registered: addressed register has a pending write
wr_en  in  NWRITE  per-port write strobe
wr_addr  in  NWRITE*AW  write addresses
wr_data  in  NWRITE*XLEN  write data
rsv_en  in  1  reserve destination register (instruction issued)
rsv_addr  in  AW  register to reserve
rsv_ok  out  1  combinational: reservation accepted this cycle

Behaviour:
- Reset (resetn=0 at posedge clk):
  - all registers, rd_data, rd_busy and scoreboard bits go to 0.
  - Writes, reads and reservations presented in that cycle are discarded.
  - rsv_ok=0 while resetn=0.
- Register 0:
  - reads always return 0, and rd_busy is always 0 for address 0;
  - writes to address 0 are ignored;
  - reserving address 0 is always accepted and is a no-op.
- Write:
  - on posedge with wr_en[j]=1 and wr_addr[j]!=0, reg[wr_addr[j]] <= wr_data[j], and busy[wr_addr[j]] clears.
  - Writing a non-busy register is legal: plain write.
  - If several write ports target the same address in one cycle, the highest port index wins.
- Read latency is 1 cycle.
  - With rd_en[i]=1 at edge N, rd_data[i]/rd_busy[i] are valid after edge N and reflect that address.
  - With rd_en[i]=0, both outputs hold their previous values.
- Bypass: if a write to the same nonzero address occurs in the read cycle, rd_data[i] takes that write's data (highest write port wins) and rd_busy[i]=0.
- Read/reserve ordering: a reservation in the read cycle is NOT visible to that read, because the reader is the older instruction. The reservation shows from the next cycle's read onward.
- Scoreboard:
  - rsv_ok = resetn & rsv_en & (rsv_addr==0 | !busy[rsv_addr] | a write to rsv_addr this cycle).
  - Accepted reservation of a nonzero address sets busy[rsv_addr] at the edge.
  - Rejected reservation (WAW on a still-pending register) leaves state unchanged; issue must stall and retry.
  - Same-cycle write-clear and reserve of the same address: the clear applies, then the set; the net result is busy=1 and rsv_ok=1.
- No out-of-range addresses exist, because DEPTH is a power of two.
- No combinational path from any input to rd_data/rd_busy; rsv_ok is the only combinational output.

Decomposition:
- Package regfile_pkg holds:
  - XLEN_DEFAULT and DEPTH_DEFAULT;
  - typedefs reg_addr_t (logic [AW-1:0]) and reg_data_t (logic [XLEN-1:0]);
  - localparam ZERO_REG = 0.
- Sub-module regfile_scoreboard (DEPTH, NWRITE) holds the busy vector, the clear/set logic and rsv_ok.
- Storage, write arbitration and registered read/bypass stay in regfile_mp.

Test Plan:
- Reset then read x5 on both ports: rd_data=0 and rd_busy=0 one cycle after rd_en; hold values with rd_en=0.
- Write x7=0xDEADBEEF, read x7 next cycle: rd_data=0xDEADBEEF. Write x0=0x1234, read x0: rd_data=0.
- Same-cycle write x3=0xA5A5A5A5 and read x3: rd_data=0xA5A5A5A5 and rd_busy=0 after that edge (bypass). With NWRITE=2, both ports write x3 (0x1 on port 0, 0x2 on port 1): x3 reads 0x2.
- Scoreboard:
  - Reserve x9: rsv_ok=1. Read x9 next cycle: rd_busy=1.
  - Reserve x9 again: rsv_ok=0, state unchanged.
  - Write x9=0x55: busy clears, and a later read gives rd_busy=0, rd_data=0x55.
  - Same-cycle write x9 plus reserve x9: rsv_ok=1, and the subsequent read shows rd_busy=1.
- Reset mid-operation: with x4 reserved and a write to x4=0xFF presented in the resetn=0 cycle, the write is discarded. Afterwards x4 reads 0 and rd_busy=0, and reserving x4 gives rsv_ok=1.
